// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding and default widths.
package pipe_pkg;
  localparam int PC_W        = 12;
  localparam int DATA_W      = 16;
  localparam int REGADDR_W   = 3;
  localparam int DMEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_e;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus a response strobe.
//   master : pipeline side (drives request, consumes response)
//   slave  : memory side
interface mem_stage_if
  import pipe_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_W,
  parameter int DATA_WIDTH      = DATA_W
);
  logic                       dmem_req_valid;
  logic                       dmem_req_ready;
  logic                       dmem_req_we;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_req_addr;
  logic [DATA_WIDTH-1:0]      dmem_req_wdata;
  logic                       dmem_rsp_valid;
  logic [DATA_WIDTH-1:0]      dmem_rsp_data;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data
  );
endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register.
//   i_bubble   : clear control bits this edge (data fields hold)
//   i_load_en  : capture i_load_data into wb_load_data
//   wb_*       : registered MEM/WB outputs, all 0 on reset
module mem_wb
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int REGADDR_WIDTH = REGADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_bubble,
  input  logic                     i_reg_write,
  input  logic                     i_mem_to_reg,
  input  logic [DATA_WIDTH-1:0]    i_alu_result,
  input  logic [REGADDR_WIDTH-1:0] i_rd,
  input  logic                     i_load_en,
  input  logic [DATA_WIDTH-1:0]    i_load_data,
  output logic                     wb_reg_write,
  output logic                     wb_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    wb_alu_result,
  output logic [DATA_WIDTH-1:0]    wb_load_data,
  output logic [REGADDR_WIDTH-1:0] wb_rd
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_rd         <= '0;
    end else begin
      if (i_bubble) begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
      end else begin
        wb_reg_write  <= i_reg_write;
        wb_mem_to_reg <= i_mem_to_reg;
        wb_alu_result <= i_alu_result;
        wb_rd         <= i_rd;
      end
      if (i_load_en) wb_load_data <= i_load_data;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
//   mem_*          : EX/MEM inputs, held stable by upstream while mem_stall=1
//   dmem           : data-memory port (request valid/ready, response strobe)
//   mem_stall      : current op does not retire this cycle
//   branch_taken/branch_target : combinational fetch redirect
//   wb_*           : MEM/WB register outputs
module mem_stage
  import pipe_pkg::*;
#(
  parameter int PC_WIDTH        = PC_W,
  parameter int DATA_WIDTH      = DATA_W,
  parameter int REGADDR_WIDTH   = REGADDR_W,
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_reg_write,
  input  logic                     mem_mem_read,
  input  logic                     mem_mem_write,
  input  logic                     mem_branch,
  input  logic [PC_WIDTH-1:0]      mem_pc,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  mem_stage_if.master              dmem,
  output logic                     mem_stall,
  output logic                     branch_taken,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic                     wb_reg_write,
  output logic                     wb_mem_to_reg,
  output logic [DATA_WIDTH-1:0]    wb_alu_result,
  output logic [DATA_WIDTH-1:0]    wb_load_data,
  output logic [REGADDR_WIDTH-1:0] wb_rd
);
  mem_state_e r_state, w_next;

  logic w_op, w_load, w_active, w_accept, w_store_done, w_load_done;

  // Read wins when both read and write are set.
  assign w_op   = mem_mem_read | mem_mem_write;
  assign w_load = mem_mem_read;
  // A transaction is live in any non-IDLE state, or in IDLE with an op.
  assign w_active = (r_state != IDLE) | w_op;

  always_comb begin
    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_req_we    = 1'b0;
    dmem.dmem_req_addr  = '0;
    dmem.dmem_req_wdata = '0;
    if (w_active) begin
      dmem.dmem_req_valid = (r_state == IDLE) | (r_state == WAIT_REQ);
      dmem.dmem_req_we    = ~w_load;
      dmem.dmem_req_addr  = mem_alu_result[DMEM_ADDR_WIDTH-1:0];
      dmem.dmem_req_wdata = mem_write_data;
    end
  end

  assign w_accept     = dmem.dmem_req_valid & dmem.dmem_req_ready;
  assign w_store_done = w_accept & ~w_load;
  // Response only counts while waiting for it; stray strobes are dropped.
  assign w_load_done  = (r_state == WAIT_RSP) & dmem.dmem_rsp_valid;

  always_comb begin
    mem_stall = 1'b0;
    w_next    = r_state;
    unique case (r_state)
      IDLE: if (w_op) begin
        mem_stall = ~w_store_done;
        if (w_accept) w_next = w_load ? WAIT_RSP : IDLE;
        else          w_next = WAIT_REQ;
      end
      WAIT_REQ: begin
        mem_stall = ~w_store_done;
        if (w_accept) w_next = w_load ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        mem_stall = ~dmem.dmem_rsp_valid;
        if (dmem.dmem_rsp_valid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  assign branch_taken  = mem_branch & (mem_alu_result == '0) & ~mem_stall;
  assign branch_target = mem_pc;

  mem_wb #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REGADDR_WIDTH(REGADDR_WIDTH)
  ) u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .i_bubble     (mem_stall),
    .i_reg_write  (mem_reg_write),
    .i_mem_to_reg (mem_mem_read),
    .i_alu_result (mem_alu_result),
    .i_rd         (mem_rd),
    .i_load_en    (w_load_done),
    .i_load_data  (dmem.dmem_rsp_data),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result),
    .wb_load_data (wb_load_data),
    .wb_rd        (wb_rd)
  );
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch;
  logic [11:0] mem_pc;
  logic [15:0] mem_alu_result, mem_write_data;
  logic [2:0]  mem_rd;
  logic        mem_stall, branch_taken;
  logic [11:0] branch_target;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [15:0] wb_alu_result, wb_load_data;
  logic [2:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.DMEM_ADDR_WIDTH(12), .DATA_WIDTH(16)) dm ();

  mem_stage #(
    .PC_WIDTH(12), .DATA_WIDTH(16), .REGADDR_WIDTH(3), .DMEM_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_rd(mem_rd),
    .dmem(dm.master),
    .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_rd(wb_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after posedge; outputs are sampled at the negedge.
  task automatic to_mid();  @(negedge clk); endtask
  task automatic to_next(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0; mem_branch = 0;
    mem_pc = '0; mem_alu_result = '0; mem_write_data = '0; mem_rd = '0;
    dm.dmem_req_ready = 0; dm.dmem_rsp_valid = 0; dm.dmem_rsp_data = '0;
  endtask

  typedef struct {
    logic rw, rd_en, wr_en, br;
    logic [11:0] pc;
    logic [15:0] alu, wd;
    logic [2:0]  rd;
    logic        rdy;
    logic        e_vld, e_we;
    logic [11:0] e_addr;
    logic        e_stall, e_tkn;
  } vec_t;

  vec_t tv[6];

  initial begin
    // rw rd wr br  pc       alu       wd        rd   rdy  vld we addr    stall tkn
    tv[0] = '{1, 0, 0, 0, 12'h000, 16'h1234, 16'h0000, 3'd5, 0, 0, 0, 12'h000, 0, 0};
    tv[1] = '{0, 0, 1, 0, 12'h000, 16'h0042, 16'hBEEF, 3'd0, 1, 1, 1, 12'h042, 0, 0};
    tv[2] = '{0, 0, 0, 1, 12'h0A0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 12'h000, 0, 1};
    tv[3] = '{0, 0, 0, 1, 12'h0A0, 16'h0001, 16'h0000, 3'd0, 0, 0, 0, 12'h000, 0, 0};
    tv[4] = '{0, 0, 1, 1, 12'h0FF, 16'h0000, 16'h1357, 3'd0, 1, 1, 1, 12'h000, 0, 1};
    tv[5] = '{1, 0, 0, 0, 12'h000, 16'hFFFF, 16'h0000, 3'd7, 1, 0, 0, 12'h000, 0, 0};

    idle_inputs();
    reset = 1;
    #12;
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_mem_to_reg", wb_mem_to_reg, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_load", wb_load_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_req_valid", dm.dmem_req_valid, 0);
    chk("rst_stall", mem_stall, 0);
    @(negedge clk); reset = 0;
    to_next();

    // Table: single-cycle cases that start and end in IDLE.
    for (int i = 0; i < 6; i++) begin
      mem_reg_write = tv[i].rw; mem_mem_read = tv[i].rd_en; mem_mem_write = tv[i].wr_en;
      mem_branch = tv[i].br; mem_pc = tv[i].pc; mem_alu_result = tv[i].alu;
      mem_write_data = tv[i].wd; mem_rd = tv[i].rd; dm.dmem_req_ready = tv[i].rdy;
      to_mid();
      chk($sformatf("v%0d_req_valid", i), dm.dmem_req_valid, tv[i].e_vld);
      chk($sformatf("v%0d_we", i), dm.dmem_req_we, tv[i].e_we);
      chk($sformatf("v%0d_addr", i), dm.dmem_req_addr, tv[i].e_addr);
      if (tv[i].e_vld) chk($sformatf("v%0d_wdata", i), dm.dmem_req_wdata, tv[i].wd);
      chk($sformatf("v%0d_stall", i), mem_stall, tv[i].e_stall);
      chk($sformatf("v%0d_taken", i), branch_taken, tv[i].e_tkn);
      chk($sformatf("v%0d_target", i), branch_target, tv[i].pc);
      to_next();
      chk($sformatf("v%0d_wb_reg_write", i), wb_reg_write, tv[i].rw);
      chk($sformatf("v%0d_wb_mem_to_reg", i), wb_mem_to_reg, 0);
      chk($sformatf("v%0d_wb_alu", i), wb_alu_result, tv[i].alu);
      chk($sformatf("v%0d_wb_rd", i), wb_rd, tv[i].rd);
    end

    // Load: ready low 2 cycles, accept in 3rd, response 3 cycles after accept.
    idle_inputs();
    mem_reg_write = 1; mem_mem_read = 1; mem_alu_result = 16'h0010; mem_rd = 3'd3;
    mem_branch = 1; mem_pc = 12'h123;
    for (int c = 0; c < 6; c++) begin
      dm.dmem_req_ready = (c == 2);
      dm.dmem_rsp_valid = (c == 5);
      dm.dmem_rsp_data  = (c == 5) ? 16'hCAFE : 16'h5555;
      to_mid();
      chk($sformatf("ld%0d_stall", c), mem_stall, (c < 5));
      chk($sformatf("ld%0d_req_valid", c), dm.dmem_req_valid, (c < 3));
      if (c < 3) begin
        chk($sformatf("ld%0d_we", c), dm.dmem_req_we, 0);
        chk($sformatf("ld%0d_addr", c), dm.dmem_req_addr, 12'h010);
      end
      // alu_result != 0 so never taken; stall would also block it.
      chk($sformatf("ld%0d_taken", c), branch_taken, 0);
      to_next();
      if (c < 5) chk($sformatf("ld%0d_wb_bubble", c), wb_reg_write, 0);
    end
    chk("ld_wb_reg_write", wb_reg_write, 1);
    chk("ld_wb_mem_to_reg", wb_mem_to_reg, 1);
    chk("ld_wb_load", wb_load_data, 16'hCAFE);
    chk("ld_wb_rd", wb_rd, 3);

    // Stray response in IDLE with no op.
    idle_inputs();
    dm.dmem_rsp_valid = 1; dm.dmem_rsp_data = 16'hFFFF;
    to_mid();
    chk("stray_stall", mem_stall, 0);
    to_next();
    chk("stray_wb_load", wb_load_data, 16'hCAFE);
    dm.dmem_rsp_valid = 0;
    to_mid();
    chk("stray_idle_stall", mem_stall, 0);
    to_next();

    // Store stalled one cycle in WAIT_REQ, then accepted.
    idle_inputs();
    mem_mem_write = 1; mem_alu_result = 16'h0777; mem_write_data = 16'hA5A5;
    to_mid();
    chk("st_wait_stall", mem_stall, 1);
    to_next();
    chk("st_wait_bubble", wb_reg_write, 0);
    dm.dmem_req_ready = 1;
    to_mid();
    chk("st_acc_req_valid", dm.dmem_req_valid, 1);
    chk("st_acc_wdata", dm.dmem_req_wdata, 16'hA5A5);
    chk("st_acc_stall", mem_stall, 0);
    to_next();
    idle_inputs();
    to_mid();
    chk("st_after_valid", dm.dmem_req_valid, 0);
    to_next();

    // Read+write together behaves as a load; reset while in WAIT_RSP.
    mem_reg_write = 1; mem_mem_read = 1; mem_mem_write = 1;
    mem_alu_result = 16'h0020; mem_rd = 3'd6; dm.dmem_req_ready = 1;
    to_mid();
    chk("rw_we", dm.dmem_req_we, 0);
    chk("rw_stall", mem_stall, 1);
    to_next();
    to_mid();
    chk("rsp_wait_valid", dm.dmem_req_valid, 0);
    chk("rsp_wait_stall", mem_stall, 1);
    reset = 1;
    idle_inputs();
    #2;
    chk("rst_mid_wb_load", wb_load_data, 0);
    to_next();
    reset = 0;
    dm.dmem_rsp_valid = 1; dm.dmem_rsp_data = 16'hDEAD;
    to_mid();
    chk("late_stall", mem_stall, 0);
    chk("late_req_valid", dm.dmem_req_valid, 0);
    to_next();
    dm.dmem_rsp_valid = 0;
    chk("late_wb_reg_write", wb_reg_write, 0);
    chk("late_wb_mem_to_reg", wb_mem_to_reg, 0);
    chk("late_wb_alu", wb_alu_result, 0);
    chk("late_wb_load", wb_load_data, 0);
    chk("late_wb_rd", wb_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
